// File: rtl/usb11_pkg.sv
// usb11_pkg: shared states and protocol constants for the usb11 transmitter
package usb11_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SYNC    = 3'd1,
        S_PID     = 3'd2,
        S_DATA    = 3'd3,
        S_EOP_SE0 = 3'd4,
        S_EOP_J   = 3'd5
    } state_t;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;

    localparam logic [7:0] SYNC_BYTE   = 8'h80;
    localparam logic [2:0] STUFF_LIMIT = 3'd6;

endpackage

// File: rtl/usb11_tx_encoder.sv
// usb11_tx_encoder: bit stuffing and NRZI line driver for usb11_tx
module usb11_tx_encoder
    import usb11_pkg::*;
(
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    input  logic bit_strobe,
    input  logic bit_in,
    input  logic force_se0,
    input  logic force_j,
    output logic d_plus,
    output logic d_minus,
    output logic stuff_pending
);
    logic [2:0] ones, ones_base;

    assign ones_base = clear ? 3'd0 : ones;
    assign stuff_pending = ones_base == STUFF_LIMIT;

    // A pending stuff bit overrides bit_in; a held 1 leaves both lines untouched
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            d_plus  <= 1'b1;
            d_minus <= 1'b0;
            ones    <= 3'd0;
        end else if (bit_strobe) begin
            if (force_se0) begin
                d_plus  <= 1'b0;
                d_minus <= 1'b0;
            end else if (force_j) begin
                d_plus  <= 1'b1;
                d_minus <= 1'b0;
            end else if (stuff_pending || !bit_in) begin
                d_plus  <= ~d_plus;
                d_minus <= d_plus;
                ones    <= 3'd0;
            end else begin
                ones <= ones_base + 3'd1;
            end
        end
    end

endmodule

// File: rtl/usb11_tx.sv
// usb11_tx: USB 1.1 full-speed packet transmitter (SYNC, PID, payload, EOP)
module usb11_tx
    import usb11_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       tx_start,
    input  logic [3:0] tx_pid,
    input  logic       tx_empty,
    input  logic [7:0] tx_r_data,
    output logic       tx_r_enable,
    output logic       d_plus,
    output logic       d_minus,
    output logic       tx_busy,
    output logic       tx_done
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

    state_t        state;
    logic [TW-1:0] tmr;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg, pid_byte;
    logic [3:0]    pid;
    logic accept, tick, shifting, stuff_pending, adv, byte_end, is_data, load, to_eop;
    logic bit_in, force_se0, force_j;

    assign accept    = state == S_IDLE && tx_start;
    assign tick      = state != S_IDLE && tmr == LAST;
    assign shifting  = state == S_SYNC || state == S_PID || state == S_DATA;
    assign adv       = tick && shifting && !stuff_pending;
    assign byte_end  = adv && bit_cnt == 3'd7;
    assign is_data   = pid == PID_DATA0 || pid == PID_DATA1;
    assign load      = byte_end && (state == S_DATA || (state == S_PID && is_data)) && !tx_empty;
    assign to_eop    = byte_end && state != S_SYNC && !load;
    assign pid_byte  = {~pid, pid};
    // The bit for the coming period: byte boundaries take bit 0 of whatever byte is loaded now
    assign bit_in    = accept ? SYNC_BYTE[0] : !byte_end ? shreg[1] : state == S_SYNC ? pid_byte[0] : tx_r_data[0];
    assign force_se0 = to_eop || (state == S_EOP_SE0 && !bit_cnt[0]);
    assign force_j   = (state == S_EOP_SE0 && bit_cnt[0]) || state == S_EOP_J;

    assign tx_r_enable = load;
    assign tx_busy     = state != S_IDLE;

    usb11_tx_encoder u_enc (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (accept),
        .bit_strobe   (accept || tick),
        .bit_in       (bit_in),
        .force_se0    (force_se0),
        .force_j      (force_j),
        .d_plus       (d_plus),
        .d_minus      (d_minus),
        .stuff_pending(stuff_pending)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= S_IDLE;
            tmr     <= '0;
            bit_cnt <= 3'd0;
            shreg   <= 8'h00;
            pid     <= 4'h0;
            tx_done <= 1'b0;
        end else begin
            tx_done <= tick && state == S_EOP_J;
            tmr     <= (state == S_IDLE || tmr == LAST) ? '0 : tmr + 1'b1;
            if (accept) begin
                state   <= S_SYNC;
                pid     <= tx_pid;
                shreg   <= SYNC_BYTE;
                bit_cnt <= 3'd0;
            end else if (adv) begin
                bit_cnt <= bit_cnt + 3'd1;
                shreg   <= !byte_end ? shreg >> 1 : state == S_SYNC ? pid_byte : tx_r_data;
                state   <= (byte_end && state == S_SYNC) ? S_PID : to_eop ? S_EOP_SE0 : load ? S_DATA : state;
            end else if (tick && state == S_EOP_SE0) begin
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt[0]) state <= S_EOP_J;
            end else if (tick && state == S_EOP_J) begin
                state <= S_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_usb11_tx.sv
// tb_usb11_tx: directed and random packets checked against a bit-level line model
module tb_usb11_tx;
    import usb11_pkg::*;

    localparam int CPB = 8;

    logic       tb_clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       tx_start = 1'b0;
    logic [3:0] tx_pid = 4'h0;
    logic       tx_empty = 1'b1;
    logic [7:0] tx_r_data = 8'h00;
    logic       tx_r_enable, d_plus, d_minus, tx_busy, tx_done;

    int n_assert = 0;
    int n_fail = 0;
    logic [7:0] fifo[$];
    logic [7:0] none[$];
    logic [7:0] pl[$];
    logic [1:0] exp_q[$];
    int         done_at;

    always #5 tb_clk = ~tb_clk;

    usb11_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (tb_clk),
        .n_rst      (n_rst),
        .tx_start   (tx_start),
        .tx_pid     (tx_pid),
        .tx_empty   (tx_empty),
        .tx_r_data  (tx_r_data),
        .tx_r_enable(tx_r_enable),
        .d_plus     (d_plus),
        .d_minus    (d_minus),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [1:0] v, input int nbits);
        repeat (nbits * CPB) exp_q.push_back(v);
    endtask

    // Expected {d_plus,d_minus} per clock: bits LSB first, stuff after six 1s, NRZI from J, EOP
    task automatic model(input logic [3:0] pid, input logic [7:0] data[$]);
        logic [7:0] bytes[$];
        int   ones;
        logic lvl, b;
        ones = 0;
        lvl = 1'b1;
        exp_q.delete();
        bytes.push_back(8'h80);
        bytes.push_back({~pid, pid});
        if (pid == PID_DATA0 || pid == PID_DATA1)
            foreach (data[i]) bytes.push_back(data[i]);
        foreach (bytes[i]) begin
            for (int k = 0; k < 8; k++) begin
                b = bytes[i][k];
                lvl = b ? lvl : ~lvl;
                put({lvl, ~lvl}, 1);
                ones = b ? ones + 1 : 0;
                if (ones == 6) begin
                    lvl = ~lvl;
                    put({lvl, ~lvl}, 1);
                    ones = 0;
                end
            end
        end
        put(2'b00, 2);
        put(2'b10, 1);
    endtask

    task automatic drive_fifo();
        tx_empty = fifo.size() == 0;
        tx_r_data = tx_empty ? 8'h00 : fifo[0];
    endtask

    task automatic send(input logic [3:0] pid, input logic [7:0] data[$], input string tag);
        int rd, bad, busy_bad, inj, want_rd;
        logic [1:0] obs[$];
        rd = 0; bad = 0; busy_bad = 0;
        done_at = 0;
        model(pid, data);
        fifo = data;
        inj = $urandom_range(2, 120);
        want_rd = (pid == PID_DATA0 || pid == PID_DATA1) ? data.size() : 0;
        @(negedge tb_clk);
        tx_start = 1'b1;
        tx_pid = pid;
        drive_fifo();
        for (int c = 1; c <= exp_q.size() + 40 && done_at == 0; c++) begin
            @(negedge tb_clk);
            tx_start = (c == inj);
            tx_pid = 4'($urandom);
            drive_fifo();
            #1;
            if (tx_done) done_at = c;
            else begin
                obs.push_back({d_plus, d_minus});
                if (!tx_busy) busy_bad++;
            end
            if (tx_r_enable) begin
                rd++;
                if (fifo.size() > 0) void'(fifo.pop_front());
            end
        end
        tx_start = 1'b0;
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++)
            if (obs[i] !== exp_q[i]) bad++;
        check({tag, " length"}, obs.size(), exp_q.size());
        check({tag, " line trace errors"}, bad, 0);
        check({tag, " done cycle"}, done_at, exp_q.size() + 1);
        check({tag, " fifo pops"}, rd, want_rd);
        check({tag, " busy gaps"}, busy_bad, 0);
        check({tag, " busy at done"}, tx_busy, 1'b0);
        @(negedge tb_clk);
        #1;
        check({tag, " done single pulse"}, tx_done, 1'b0);
        check({tag, " idle J"}, {d_plus, d_minus}, 2'b10);
        fifo.delete();
        drive_fifo();
    endtask

    initial begin
        logic [3:0] pids[6];
        pids = '{PID_OUT, PID_IN, PID_DATA0, PID_DATA1, PID_ACK, PID_NAK};
        repeat (3) @(negedge tb_clk);
        #1;
        check("reset d_plus", d_plus, 1'b1);
        check("reset d_minus", d_minus, 1'b0);
        check("reset busy", tx_busy, 1'b0);
        check("reset r_enable", tx_r_enable, 1'b0);
        check("reset done", tx_done, 1'b0);
        n_rst = 1'b1;

        send(PID_ACK, none, "ack");
        check("ack total", done_at, 1 + 16 * 8 + 24);

        pl = '{8'hFF};
        send(PID_DATA0, pl, "data0_ff");
        check("data0_ff total", done_at, 1 + 25 * 8 + 24);

        send(PID_DATA1, none, "data1_empty");
        check("data1_empty total", done_at, 1 + 16 * 8 + 24);

        pl = '{8'hA5, 8'h7E, 8'hFF};
        send(PID_DATA0, pl, "data0_3b");

        pl = '{8'hFC};
        send(PID_DATA1, pl, "stuff_before_eop");

        pl = '{8'h11, 8'h22};
        send(PID_NAK, pl, "nak_ignores_fifo");

        // Abort in the middle of PID bit 3
        @(negedge tb_clk);
        tx_start = 1'b1;
        tx_pid = PID_ACK;
        @(negedge tb_clk);
        tx_start = 1'b0;
        repeat (8 * 8 + 3 * 8 + 3) @(negedge tb_clk);
        #1;
        check("abort busy before", tx_busy, 1'b1);
        n_rst = 1'b0;
        #1;
        check("abort d_plus", d_plus, 1'b1);
        check("abort d_minus", d_minus, 1'b0);
        check("abort busy", tx_busy, 1'b0);
        check("abort r_enable", tx_r_enable, 1'b0);
        repeat (2) @(negedge tb_clk);
        #1;
        check("abort hold J", {d_plus, d_minus}, 2'b10);
        n_rst = 1'b1;
        send(PID_ACK, none, "ack_after_abort");

        for (int t = 0; t < 10; t++) begin
            int len;
            len = $urandom_range(0, 4);
            pl.delete();
            for (int j = 0; j < len; j++) pl.push_back($urandom_range(0, 3) == 0 ? 8'hFF : 8'($urandom));
            send(pids[$urandom_range(0, 5)], pl, $sformatf("rand%0d", t));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
